// File: rtl/mio_pkg.sv
// Shared constants, state encoding and helpers for the MIO bus responder.
package mio_pkg;

   localparam logic [31:0] LED_ADDR   = 32'hE000_0000;
   localparam logic [31:0] SW_ADDR    = 32'hE000_0004;
   localparam logic [31:0] TCNT_ADDR  = 32'hF000_0000;
   localparam logic [31:0] TCMP_ADDR  = 32'hF000_0004;
   localparam logic [31:0] TCTRL_ADDR = 32'hF000_0008;
   localparam logic [31:0] TSTAT_ADDR = 32'hF000_000C;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_AR   = 1;
   localparam int CTRL_IE   = 4;
   localparam int STAT_PEND = 0;
   localparam int STAT_BERR = 1;

   localparam logic [31:0] CTRL_MASK = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      R_RAM,
      R_LED,
      R_SW,
      R_TCNT,
      R_TCMP,
      R_TCTRL,
      R_TSTAT,
      R_NONE
   } region_e;

   function automatic region_e decode(
      input logic [31:2] wa,
      input int          aw
   );
      region_e r;
      r = R_NONE;
      if ((wa >> aw) == '0)
         r = R_RAM;
      else if (wa == LED_ADDR[31:2])
         r = R_LED;
      else if (wa == SW_ADDR[31:2])
         r = R_SW;
      else if (wa == TCNT_ADDR[31:2])
         r = R_TCNT;
      else if (wa == TCMP_ADDR[31:2])
         r = R_TCMP;
      else if (wa == TCTRL_ADDR[31:2])
         r = R_TCTRL;
      else if (wa == TSTAT_ADDR[31:2])
         r = R_TSTAT;
      return r;
   endfunction

   function automatic logic [31:0] lane_merge(
      input logic [31:0] old,
      input logic [31:0] nw,
      input logic [3:0]  be
   );
      logic [31:0] r;
      for (int b = 0; b < 4; b++)
         r[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
      return r;
   endfunction

endpackage

// File: rtl/mio_bus_responder_if.sv
// Core-to-responder memory/IO request bus.
interface mio_bus_responder_if;

   logic        CPU_MIO;
   logic        mem_w;
   logic [31:0] Addr_out;
   logic [31:0] Data_out;
   logic [3:0]  WEA;
   logic [31:0] Data_in;
   logic        MIO_ready;

   modport master (
      output CPU_MIO,
      output mem_w,
      output Addr_out,
      output Data_out,
      output WEA,
      input  Data_in,
      input  MIO_ready
   );

   modport slave (
      input  CPU_MIO,
      input  mem_w,
      input  Addr_out,
      input  Data_out,
      input  WEA,
      output Data_in,
      output MIO_ready
   );

endinterface

// File: rtl/mio_timer.sv
// 32-bit compare timer with auto-reload and a registered interrupt.
module mio_timer
   import mio_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  wea_i,
   output logic [31:0] rdata_o,
   output logic        irq_o
);

   logic [31:0] tcnt_q, tcnt_d;
   logic [31:0] tcmp_q, tcmp_d;
   logic [31:0] ctrl_q, ctrl_d;
   logic        pend_q, pend_d;
   logic        irq_q, irq_d;
   logic        match;

   assign match = ctrl_q[CTRL_EN] && (tcnt_q == tcmp_q);

   always_comb begin
      tcnt_d = tcnt_q;
      tcmp_d = tcmp_q;
      ctrl_d = ctrl_q;
      pend_d = pend_q;
      if (ctrl_q[CTRL_EN])
         tcnt_d = (match && ctrl_q[CTRL_AR]) ? '0 : tcnt_q + 32'd1;
      // bus writes override counting; a hardware set beats a W1C
      if (we_i) begin
         unique case (off_i)
            2'd0: tcnt_d = lane_merge(tcnt_q, wdata_i, wea_i);
            2'd1: tcmp_d = lane_merge(tcmp_q, wdata_i, wea_i);
            2'd2: ctrl_d = lane_merge(ctrl_q, wdata_i, wea_i) & CTRL_MASK;
            2'd3: if (wea_i[0] && wdata_i[STAT_PEND]) pend_d = 1'b0;
         endcase
      end
      if (match)
         pend_d = 1'b1;
      irq_d = pend_q & ctrl_q[CTRL_IE];
   end

   always_comb begin
      rdata_o = '0;
      unique case (off_i)
         2'd0: rdata_o = tcnt_q;
         2'd1: rdata_o = tcmp_q;
         2'd2: rdata_o = ctrl_q;
         2'd3: rdata_o = {31'd0, pend_q};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt_q <= '0;
         tcmp_q <= '0;
         ctrl_q <= '0;
         pend_q <= 1'b0;
         irq_q  <= 1'b0;
      end else begin
         tcnt_q <= tcnt_d;
         tcmp_q <= tcmp_d;
         ctrl_q <= ctrl_d;
         pend_q <= pend_d;
         irq_q  <= irq_d;
      end
   end

   assign irq_o = irq_q;

endmodule

// File: rtl/mio_bus_responder.sv
// Bus target: word RAM, LED/switch GPIO and compare timer behind a
// wait-state FSM that answers each request with a one-cycle ready pulse.
module mio_bus_responder
   import mio_pkg::*;
#(
   parameter int RAM_AW      = 10,
   parameter int WAIT_CYCLES = 1,
   parameter int LED_W       = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   mio_bus_responder_if.slave   bus,
   output logic                 INT,
   input  logic [15:0]          sw_i,
   output logic [LED_W-1:0]     led_o
);

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_e           state_q, state_d;
   logic [3:0]       wcnt_q, wcnt_d;
   logic [31:2]      addr_q;
   logic [31:0]      wdata_q;
   logic [3:0]       wea_q;
   logic             we_q;
   logic [31:0]      din_q, din_d;
   logic [LED_W-1:0] led_q, led_d;
   logic             berr_q, berr_d;

   logic [31:0]      mem [2**RAM_AW];

   logic [31:2]      cur_wa;
   logic             cur_we;
   region_e          reg_sel;
   logic [RAM_AW-1:0] idx;
   logic [31:0]      rd_data;
   logic [31:0]      tmr_rdata;
   logic [31:0]      led_ext;
   logic [31:0]      led_m;
   logic             tmr_sel;
   logic             do_wr;
   logic             accept;
   logic             irq;

   // in IDLE the request is still on the bus, afterwards it is latched
   assign cur_wa  = (state_q == S_IDLE) ? bus.Addr_out[31:2] : addr_q;
   assign cur_we  = (state_q == S_IDLE) ? bus.mem_w : we_q;
   assign reg_sel = decode(cur_wa, RAM_AW);
   assign idx     = cur_wa[RAM_AW+1:2];
   assign led_ext = 32'(led_q);
   assign accept  = (state_q == S_IDLE) && bus.CPU_MIO;
   assign do_wr   = (state_q == S_DONE) && we_q;
   assign tmr_sel = (reg_sel == R_TCNT) || (reg_sel == R_TCMP) ||
                    (reg_sel == R_TCTRL) || (reg_sel == R_TSTAT);

   mio_timer u_timer (
      .clk     (clk),
      .rst_n   (reset),
      .we_i    (do_wr && tmr_sel),
      .off_i   (cur_wa[3:2]),
      .wdata_i (wdata_q),
      .wea_i   (wea_q),
      .rdata_o (tmr_rdata),
      .irq_o   (irq)
   );

   always_comb begin
      rd_data = '0;
      unique case (reg_sel)
         R_RAM:   rd_data = mem[idx];
         R_LED:   rd_data = led_ext;
         R_SW:    rd_data = 32'(sw_i);
         R_TCNT,
         R_TCMP,
         R_TCTRL: rd_data = tmr_rdata;
         R_TSTAT: begin
            rd_data = tmr_rdata;
            rd_data[STAT_BERR] = berr_q;
         end
         default: rd_data = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      din_d   = din_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.CPU_MIO) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT;
                  wcnt_d  = WAIT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (wcnt_q <= 4'd1)
               state_d = S_DONE;
            else
               wcnt_d = wcnt_q - 4'd1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // read data is captured on entry so it is valid alongside MIO_ready
      if (state_d == S_DONE && state_q != S_DONE)
         din_d = cur_we ? '0 : rd_data;
   end

   always_comb begin
      led_d  = led_q;
      berr_d = berr_q;
      led_m  = lane_merge(led_ext, wdata_q, wea_q);
      if (do_wr && reg_sel == R_LED)
         led_d = led_m[LED_W-1:0];
      if (do_wr && reg_sel == R_TSTAT && wea_q[0] && wdata_q[STAT_BERR])
         berr_d = 1'b0;
      if (state_q == S_DONE &&
          (reg_sel == R_NONE || (reg_sel == R_SW && we_q)))
         berr_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wea_q   <= '0;
         we_q    <= 1'b0;
         din_q   <= '0;
         led_q   <= '0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         din_q   <= din_d;
         led_q   <= led_d;
         berr_q  <= berr_d;
         if (accept) begin
            addr_q  <= bus.Addr_out[31:2];
            wdata_q <= bus.Data_out;
            wea_q   <= bus.WEA;
            we_q    <= bus.mem_w;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr && reg_sel == R_RAM) begin
         for (int b = 0; b < 4; b++)
            if (wea_q[b])
               mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
   end

   assign bus.Data_in   = din_q;
   assign bus.MIO_ready = (state_q == S_DONE);
   assign INT           = irq;
   assign led_o         = led_q;

endmodule
